// File: rtl/wait_state_ram.sv
// Single-port synchronous RAM behind the CPU bus cs_/as_/rdy_ handshake, with byte
// enables and WAIT_STATES programmable latency.
// Define MEM_PARITY_EN to store one even-parity bit per byte and flag mismatches on reads.
module wait_state_ram #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs_,
  input  logic                as_,
  input  logic                rw,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rdy_,
  output logic                busy,
  output logic                par_err
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned NB       = DATA_W / 8;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned CNT_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  logic [DATA_W-1:0] mem [DEPTH];
`ifdef MEM_PARITY_EN
  logic [NB-1:0]     par_mem [DEPTH];
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              par_err_q, par_err_d;

  logic              enter_ack_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic              acc_rw_c;
  logic [NB-1:0]     acc_be_c;
  logic [DATA_W-1:0] acc_wdata_c;
  logic              par_bad_c;

  // Next-state, request latch and access completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    par_err_d = 1'b0;
    par_bad_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!cs_ && !as_) begin
          addr_d  = addr;
          rw_d    = rw;
          be_d    = be;
          wdata_d = wr_data;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(CNT_INIT);
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // With zero wait states ACK is entered straight from IDLE, before the latch holds the request.
    acc_addr_c  = (state_q == S_IDLE) ? addr    : addr_q;
    acc_rw_c    = (state_q == S_IDLE) ? rw      : rw_q;
    acc_be_c    = (state_q == S_IDLE) ? be      : be_q;
    acc_wdata_c = (state_q == S_IDLE) ? wr_data : wdata_q;
    enter_ack_c = (state_d == S_ACK) && (state_q != S_ACK);

`ifdef MEM_PARITY_EN
    for (int i = 0; i < int'(NB); i++)
      par_bad_c = par_bad_c | (par_mem[acc_addr_c][i] ^ (^mem[acc_addr_c][8*i +: 8]));
`endif

    if (enter_ack_c && acc_rw_c) begin
      rd_data_d = mem[acc_addr_c];
      par_err_d = par_bad_c;
    end

    rdy_d  = (state_d != S_ACK);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b1;
      be_q      <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      par_err_q <= par_err_d;
    end
  end

  // Storage is not reset; a reset cycle suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!reset && enter_ack_c && !acc_rw_c) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (acc_be_c[i]) begin
          mem[acc_addr_c][8*i +: 8] <= acc_wdata_c[8*i +: 8];
`ifdef MEM_PARITY_EN
          par_mem[acc_addr_c][i] <= ^acc_wdata_c[8*i +: 8];
`endif
        end
      end
    end
  end

  assign rd_data = rd_data_q;
  assign rdy_    = rdy_q;
  assign busy    = busy_q;
  assign par_err = par_err_q;

endmodule

// File: tb/tb_wait_state_ram.sv
// Bench for wait_state_ram: one instance with zero wait states and one with three,
// each checked against a word-array memory model and the bus latency rule.
module tb_wait_state_ram;

  logic        clk = 1'b0;
  logic        reset   [2];
  logic        cs_n    [2];
  logic        as_n    [2];
  logic        rw      [2];
  logic [11:0] addr    [2];
  logic [3:0]  be      [2];
  logic [31:0] wr_data [2];
  logic [31:0] rd_data [2];
  logic        rdy_n   [2];
  logic        busy    [2];
  logic        par_err [2];

  logic [31:0] mdl     [2][4096];
  bit          known   [2][4096];
  logic [31:0] last_rd [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wait_state_ram #(.ADDR_W(12), .DATA_W(32), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset[0]), .cs_(cs_n[0]), .as_(as_n[0]), .rw(rw[0]),
    .addr(addr[0]), .be(be[0]), .wr_data(wr_data[0]), .rd_data(rd_data[0]),
    .rdy_(rdy_n[0]), .busy(busy[0]), .par_err(par_err[0]));

  wait_state_ram #(.ADDR_W(12), .DATA_W(32), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset[1]), .cs_(cs_n[1]), .as_(as_n[1]), .rw(rw[1]),
    .addr(addr[1]), .be(be[1]), .wr_data(wr_data[1]), .rd_data(rd_data[1]),
    .rdy_(rdy_n[1]), .busy(busy[1]), .par_err(par_err[1]));

  function automatic int ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single strobe; checks busy, latency, read data, rd_data hold on writes, parity flag.
  task automatic access(input int d, input logic r, input logic [11:0] a,
                        input logic [3:0] b, input logic [31:0] w, input logic exp_perr);
    int          k;
    bit          seen;
    logic [31:0] word;
    cs_n[d] = 1'b0; as_n[d] = 1'b0; rw[d] = r; addr[d] = a; be[d] = b; wr_data[d] = w;
    tick();
    cs_n[d] = 1'b1; as_n[d] = 1'b1;
    k = 1; seen = 0;
    while (k <= 20 && !seen) begin
      n_tests++;
      if (busy[d] !== 1'b1) begin
        n_fail++; $display("FAIL busy_during_access d%0d k=%0d: got %b want 1", d, k, busy[d]);
      end
      if (rdy_n[d] === 1'b0) seen = 1;
      else begin tick(); k++; end
    end
    n_tests++;
    if (!seen || k != ws(d) + 1) begin
      n_fail++; $display("FAIL latency d%0d addr %h: got %0d want %0d", d, a, seen ? k : -1, ws(d) + 1);
    end
    if (!r) begin
      word = mdl[d][a];
      for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = w[8*i +: 8];
      mdl[d][a] = word;
      if (b == 4'hF) known[d][a] = 1;
    end else begin
      last_rd[d] = mdl[d][a];
    end
    n_tests++;
    if (rd_data[d] !== last_rd[d]) begin
      n_fail++; $display("FAIL rd_data d%0d addr %h rw=%b: got %h want %h", d, a, r, rd_data[d], last_rd[d]);
    end
    n_tests++;
    if (par_err[d] !== exp_perr) begin
      n_fail++; $display("FAIL par_err d%0d addr %h: got %b want %b", d, a, par_err[d], exp_perr);
    end
    tick();
    n_tests++;
    if (rdy_n[d] !== 1'b1 || busy[d] !== 1'b0) begin
      n_fail++; $display("FAIL after_ack d%0d: got rdy_=%b busy=%b want 1/0", d, rdy_n[d], busy[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; cs_n[d] = 1'b1; as_n[d] = 1'b1; rw[d] = 1'b1;
      addr[d] = '0; be[d] = '0; wr_data[d] = '0; last_rd[d] = '0;
    end
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (rdy_n[d] !== 1'b1 || busy[d] !== 1'b0 || rd_data[d] !== 32'h0 || par_err[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state d%0d: got rdy_=%b busy=%b rd=%h perr=%b want 1/0/0/0",
                 d, rdy_n[d], busy[d], rd_data[d], par_err[d]);
      end
      reset[d] = 1'b0;
    end
    tick();
  endtask

  task automatic test_basic();
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b0, 12'h010, 4'hF, 32'hDEADBEEF, 1'b0);
      access(d, 1'b1, 12'h010, 4'hF, 32'h0, 1'b0);
      n_tests++;
      if (rd_data[d] !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL basic_read d%0d: got %h want deadbeef", d, rd_data[d]);
      end
    end
  endtask

  task automatic test_byte_enables();
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b0, 12'h030, 4'hF, 32'h11223344, 1'b0);
      access(d, 1'b0, 12'h030, 4'b0101, 32'hAABBCCDD, 1'b0);
      access(d, 1'b0, 12'h030, 4'b0000, 32'h99999999, 1'b0);
      access(d, 1'b1, 12'h030, 4'h0, 32'h0, 1'b0);
      n_tests++;
      if (rd_data[d] !== 32'h11BB33DD) begin
        n_fail++; $display("FAIL byte_enable d%0d: got %h want 11bb33dd", d, rd_data[d]);
      end
    end
  endtask

  task automatic test_partial_strobe();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 6; c++) begin
        cs_n[d] = (c < 3) ? 1'b0 : 1'b1;
        as_n[d] = (c < 3) ? 1'b1 : 1'b0;
        rw[d] = 1'b0; addr[d] = 12'h010; be[d] = 4'hF; wr_data[d] = 32'h0BADF00D;
        tick();
        n_tests++;
        if (busy[d] !== 1'b0 || rdy_n[d] !== 1'b1) begin
          n_fail++; $display("FAIL partial_strobe d%0d c=%0d: got busy=%b rdy_=%b want 0/1", d, c, busy[d], rdy_n[d]);
        end
      end
      cs_n[d] = 1'b1; as_n[d] = 1'b1;
      tick();
      access(d, 1'b1, 12'h010, 4'h0, 32'h0, 1'b0);
    end
  endtask

  // Strobe held low: accepted only in IDLE, so one rdy_ every WAIT_STATES+2 cycles.
  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      int len    = 3 * (ws(d) + 2);
      int pulses = 0;
      int bad    = 0;
      cs_n[d] = 1'b0; as_n[d] = 1'b0; rw[d] = 1'b1; addr[d] = 12'h010;
      for (int k = 1; k <= len + ws(d) + 2; k++) begin
        tick();
        if (rdy_n[d] === 1'b0) begin
          pulses++;
          if ((k - (ws(d) + 1)) % (ws(d) + 2) != 0) bad++;
          if (rd_data[d] !== mdl[d][12'h010]) bad++;
        end
        if (k == len) begin cs_n[d] = 1'b1; as_n[d] = 1'b1; end
      end
      last_rd[d] = mdl[d][12'h010];
      n_tests++;
      if (pulses != 3 || bad != 0) begin
        n_fail++; $display("FAIL back_to_back d%0d: got %0d pulses (%0d misplaced) want 3 (0)", d, pulses, bad);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    access(1, 1'b0, 12'h020, 4'hF, 32'h0, 1'b0);
    cs_n[1] = 1'b0; as_n[1] = 1'b0; rw[1] = 1'b0; addr[1] = 12'h020; be[1] = 4'hF; wr_data[1] = 32'hCAFEF00D;
    tick();
    cs_n[1] = 1'b1; as_n[1] = 1'b1;
    tick();
    reset[1] = 1'b1;
    tick();
    reset[1] = 1'b0;
    last_rd[1] = 32'h0;
    n_tests++;
    if (rdy_n[1] !== 1'b1 || busy[1] !== 1'b0 || rd_data[1] !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid d1: got rdy_=%b busy=%b rd=%h want 1/0/0", rdy_n[1], busy[1], rd_data[1]);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (rdy_n[1] !== 1'b1 || busy[1] !== 1'b0) begin
        n_fail++; $display("FAIL reset_mid_idle d1 c=%0d: got rdy_=%b busy=%b want 1/0", c, rdy_n[1], busy[1]);
      end
    end
    access(1, 1'b1, 12'h020, 4'h0, 32'h0, 1'b0);
    n_tests++;
    if (rd_data[1] !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_write d1: got %h want 00000000", rd_data[1]);
    end
  endtask

  task automatic test_boundary();
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b0, 12'hFFF, 4'hF, 32'hF00DFACE, 1'b0);
      access(d, 1'b0, 12'h000, 4'hF, 32'h01234567, 1'b0);
      access(d, 1'b1, 12'hFFF, 4'h0, 32'h0, 1'b0);
      n_tests++;
      if (rd_data[d] !== 32'hF00DFACE) begin
        n_fail++; $display("FAIL boundary_fff d%0d: got %h want f00dface", d, rd_data[d]);
      end
      access(d, 1'b1, 12'h000, 4'h0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [11:0] pool [8];
    pool[0] = 12'h000; pool[1] = 12'h001; pool[2] = 12'h7FF; pool[3] = 12'h800;
    pool[4] = 12'hFFE; pool[5] = 12'hFFF; pool[6] = 12'h123; pool[7] = 12'hABC;
    for (int n = 0; n < 80; n++) begin
      int          d = n % 2;
      logic [11:0] a = pool[$urandom_range(7)];
      logic        r = 1'($urandom_range(1));
      logic [3:0]  b = 4'($urandom_range(15));
      if (!known[d][a]) begin r = 1'b0; b = 4'hF; end
      access(d, r, a, b, $urandom, 1'b0);
    end
  endtask

`ifdef MEM_PARITY_EN
  task automatic test_parity();
    access(0, 1'b0, 12'h040, 4'hF, 32'h5A5AA5A5, 1'b0);
    access(0, 1'b1, 12'h040, 4'h0, 32'h0, 1'b0);
    dut0.par_mem[12'h040][1] = ~dut0.par_mem[12'h040][1];
    access(0, 1'b1, 12'h040, 4'h0, 32'h0, 1'b1);
  endtask
`endif

  initial begin
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 4096; a++) begin mdl[d][a] = '0; known[d][a] = 0; end
    test_reset();
    test_basic();
    test_byte_enables();
    test_partial_strobe();
    test_back_to_back();
    test_reset_mid_access();
    test_boundary();
    test_random();
`ifdef MEM_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
